mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates one single-ported 16-bit SRAM between the instruction-fetch (IF) port and the data-memory (DM) port of the CPU. It sequences each multi-cycle SRAM access and drives the select of the 16-bit 2:1 address/write-data mux (0 = IF, 1 = DM). It returns read data, an acknowledge and a stall to each port. It sits between the IF/MEM pipeline stages and the external RAM pins.

## Interface
- ACCESS_CYCLES, 2, cycles the SRAM strobe is held per access (≥1)
- STARVE_LIMIT, 3, consecutive DM grants with IF waiting before IF is forced
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF access request (read only)
- if_addr  in  16  IF address
- if_rdata  out  16  IF read data, valid while if_ack
- if_ack  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_ack (combinational)
- dm_req  in  1  DM access request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  16  DM address
- dm_wdata  in  16  DM write data
- dm_rdata  out  16  DM read data, valid while dm_ack
- dm_ack  out  1  one-cycle completion pulse
- dm_stall  out  1  dm_req & ~dm_ack (combinational)
- grant_dm  out  1  address/data mux select; 1 = DM owns the bus
- ram_addr  out  16  registered SRAM address
- ram_wdata  out  16  registered SRAM write data
- ram_rdata  in  16  SRAM read data
- ram_re  out  1  read strobe
- ram_we  out  1  write strobe

## Operation
- States: IDLE, ACCESS, DONE. Encoding is 2 bits.
- IDLE:
  - If neither port requests, stay in IDLE.
  - Otherwise pick a winner. DM wins unless the starvation counter equals STARVE_LIMIT and if_req is high; in that case IF wins.
  - On the grant edge, register grant_dm, ram_addr, ram_wdata (DM writes only) and the operation type. Load cnt=0 and go to ACCESS.
- ACCESS:
  - ram_re (read) or ram_we (write) is high.
  - cnt increments each cycle. When cnt == ACCESS_CYCLES-1, latch ram_rdata into the granted port's rdata register and go to DONE.
- DONE:
  - Assert the granted port's ack for exactly one cycle. Strobes are low.
  - ram_addr, ram_wdata and grant_dm stay held, which gives SRAM hold time.
  - Go to IDLE.
- Starvation counter (2-bit minimum, saturating at STARVE_LIMIT):
  - Increments on each DM grant made while if_req is high.
  - Clears on any IF grant, or on any grant made while if_req is low.
- A requester keeps req, addr, we and wdata stable until it sees ack. It must drop req in the cycle after ack, otherwise a new access starts.
- If req is withdrawn mid-access, the access still completes and ack is still pulsed.
- A write returns an ack; dm_rdata is left unchanged on writes.
- if_rdata and dm_rdata hold their last value between accesses.
- Reset values: state=IDLE, cnt=0, starve=0, grant_dm=0, ram_addr=0, ram_wdata=0, ram_re=0, ram_we=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
- Reset asserted mid-access aborts the access immediately. Strobes are low from the first post-reset cycle and no ack is issued.

## Timing
- req sampled high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..ACCESS_CYCLES.
  - ack is high in cycle ACCESS_CYCLES+1.
  - Latency is 3 cycles with the defaults.
- Throughput is one access per ACCESS_CYCLES+2 cycles (IDLE→ACCESS→DONE→IDLE).
- Simultaneous requests resolve in a single IDLE cycle; the loser stays stalled until its own ack.
- All outputs except the stalls are registered.
- ram_rdata is sampled on the final ACCESS edge only.

## Structure
- Shared package cpu_mem_pkg holds:
  - state constants ST_IDLE, ST_ACCESS, ST_DONE
  - default ACCESS_CYCLES and STARVE_LIMIT
  - GRANT_IF=0 and GRANT_DM=1
- Sub-module mem_grant_sel holds the priority decision and the starvation counter:
  - inputs: if_req, dm_req, grant-strobe
  - output: next grant_dm
- The FSM, cycle counter and data registers stay in the top level.

## Test plan
- Reset, then IF read of 0x0040 with ram_rdata=0x1234 → ram_re high for cycles 1–2, if_ack pulse in cycle 3, if_rdata=0x1234, grant_dm=0 throughout.
- DM write 0xBEEF to 0x8000 → ram_we high 2 cycles with ram_addr=0x8000, ram_wdata=0xBEEF, grant_dm=1; dm_ack in cycle 3; dm_rdata unchanged.
- if_req and dm_req raised together, both held → DM served first, IF ack 4 cycles after the DM ack; if_stall is high until then.
- dm_req held continuously and if_req held → exactly 3 DM grants, then an IF grant, then the counter clears and DM resumes.
- rst asserted in the second ACCESS cycle of a DM write → ram_we=0 next cycle, no dm_ack, all outputs at reset values.
- Sweep ACCESS_CYCLES=1 and 4 → ack latency of 2 and 5 cycles; strobe widths of 1 and 4.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter.
package cpu_mem_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned ACCESS_CYCLES_DEF = 2;
  localparam int unsigned STARVE_LIMIT_DEF  = 3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Request payload captured on the grant edge.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_grant_sel.sv
// Priority decision (DM first) with an IF starvation counter.
module mem_grant_sel
  import cpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_stb,
  output logic grant_dm_c
);

  localparam int unsigned SW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned SW     = (SW_RAW < 2) ? 2 : SW_RAW;

  logic [SW-1:0] starve;
  logic          if_starved;

  // IF is forced once DM has won STARVE_LIMIT times in a row over a waiting IF.
  always_comb begin
    if_starved = if_req && (starve == SW'(STARVE_LIMIT));
    grant_dm_c = (dm_req && !if_starved) ? GRANT_DM : GRANT_IF;
  end

  // Saturating count of DM grants made while IF was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (grant_stb) begin
      if ((grant_dm_c == GRANT_DM) && if_req) begin
        if (starve != SW'(STARVE_LIMIT)) starve <= starve + SW'(1);
      end else begin
        starve <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported SRAM arbiter between instruction-fetch and data-memory ports.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_stall,
  output logic        grant_dm,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_re,
  output logic        ram_we
);

  localparam int unsigned CW = cnt_width(ACCESS_CYCLES);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              op_we, op_we_nxt;
  logic              grant_nxt;
  logic [15:0]       addr_nxt, wdata_nxt;
  logic              re_nxt, we_nxt;
  logic              if_ack_nxt, dm_ack_nxt;
  logic [15:0]       if_rd_nxt, dm_rd_nxt;
  logic              grant_stb;
  logic              grant_dm_c;
  mem_req_t          sel;

  assign grant_stb = (state == ST_IDLE) && (if_req || dm_req);
  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;

  mem_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_sel (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .grant_stb  (grant_stb),
    .grant_dm_c (grant_dm_c)
  );

  // Next-state and next registered outputs; everything holds unless changed.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_we_nxt  = op_we;
    grant_nxt  = grant_dm;
    addr_nxt   = ram_addr;
    wdata_nxt  = ram_wdata;
    re_nxt     = 1'b0;
    we_nxt     = 1'b0;
    if_ack_nxt = 1'b0;
    dm_ack_nxt = 1'b0;
    if_rd_nxt  = if_rdata;
    dm_rd_nxt  = dm_rdata;
    sel        = (grant_dm_c == GRANT_DM) ?
                 '{we: dm_we, addr: dm_addr, wdata: dm_wdata} :
                 '{we: 1'b0,  addr: if_addr, wdata: 16'h0000};

    case (state)
      ST_IDLE: begin
        if (grant_stb) begin
          grant_nxt = grant_dm_c;
          addr_nxt  = sel.addr;
          op_we_nxt = sel.we;
          if (sel.we) wdata_nxt = sel.wdata;
          cnt_nxt   = '0;
          re_nxt    = !sel.we;
          we_nxt    = sel.we;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == CW'(ACCESS_CYCLES - 1)) begin
          if (!op_we) begin
            if (grant_dm == GRANT_DM) dm_rd_nxt = ram_rdata;
            else                      if_rd_nxt = ram_rdata;
          end
          if_ack_nxt = (grant_dm == GRANT_IF);
          dm_ack_nxt = (grant_dm == GRANT_DM);
          state_nxt  = ST_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
          re_nxt  = !op_we;
          we_nxt  = op_we;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_we     <= 1'b0;
      grant_dm  <= GRANT_IF;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_we     <= op_we_nxt;
      grant_dm  <= grant_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
      ram_re    <= re_nxt;
      ram_we    <= we_nxt;
      if_ack    <= if_ack_nxt;
      dm_ack    <= dm_ack_nxt;
      if_rdata  <= if_rd_nxt;
      dm_rdata  <= dm_rd_nxt;
    end
  end

endmodule
